bus_arbiter: RTL and testbench

- Round-robin arbiter that shares one 32-bit shared bus between up to 8 requesters.
- Produces a one-hot output-enable vector that drives the per-requester tristate drivers.
- Produces a binary owner index that drives the 8:1 select mux on the read side.
- Inserts a one-cycle turnaround between owners, so two tristate drivers never enable in the same cycle.

---
 rtl/bus_arbiter_pkg.sv | 22 ++
 rtl/bus_arbiter_if.sv | 17 +
 rtl/bus_arbiter_rr_pick.sv | 36 +++
 rtl/bus_arbiter.sv | 128 ++++++++++++
 tb/tb_bus_arbiter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types, defaults and index helper for the round-robin bus arbiter.
package bus_arbiter_pkg;

  localparam int DEF_NUM_REQ   = 8;
  localparam int DEF_IDX_W     = 3;
  localparam int DEF_MAX_BURST = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  // Modulo add for operands already below n; avoids a real divider.
  function automatic int unsigned wrap_add(int unsigned a, int unsigned b, int unsigned n);
    int unsigned s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface bus_arbiter_if
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = DEF_IDX_W
);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               bus_busy;

  modport master (output req, input grant, input grant_idx, input bus_busy);
  modport slave  (input req, output grant, output grant_idx, output bus_busy);

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate by ptr, find lowest set bit, rotate back.
module rr_pick
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = DEF_IDX_W
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_winner,
  output logic               o_found
);

  logic [NUM_REQ-1:0] w_rot;
  int unsigned        w_off;

  always_comb begin
    w_rot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_rot[i] = i_req[IDX_W'(wrap_add(int'(i_ptr), i, NUM_REQ))];
    end
  end

  always_comb begin
    o_found = 1'b0;
    w_off   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        o_found = 1'b1;
        w_off   = i;
      end
    end
    o_winner = IDX_W'(wrap_add(int'(i_ptr), w_off, NUM_REQ));
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin tristate bus arbiter with a one-cycle turnaround between owners.
// Optional tenure limit when BUS_ARB_BURST_LIMIT_EN is defined.
//
// state    | meaning
// ST_IDLE  | no owner, arbitrate on any request
// ST_GRANT | owner holds the bus until it drops req (or is preempted)
// ST_TURN  | single dead cycle, then arbitrate from the updated pointer
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = DEF_IDX_W
`ifdef BUS_ARB_BURST_LIMIT_EN
  , parameter int MAX_BURST = DEF_MAX_BURST
`endif
) (
  input  logic         i_clock,
  input  logic         i_reset,
  bus_arbiter_if.slave io_bus
);

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic               r_busy, w_busy_nxt;

  logic [IDX_W-1:0]   w_winner;
  logic               w_found;
  logic               w_release;
  logic               w_preempt;
  logic [IDX_W-1:0]   w_ptr_after;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req    (io_bus.req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_found  (w_found)
  );

  assign w_release   = ~io_bus.req[r_idx];
  assign w_ptr_after = IDX_W'(wrap_add(int'(r_idx), 1, NUM_REQ));

`ifdef BUS_ARB_BURST_LIMIT_EN
  localparam int TEN_W = $clog2(MAX_BURST + 1);

  logic [TEN_W-1:0]   r_tenure;
  logic [TEN_W-1:0]   w_tenure_inc;
  logic [NUM_REQ-1:0] w_others;

  // Counts cycles held including the current one, so the limit hits after exactly MAX_BURST cycles.
  assign w_tenure_inc = (r_tenure == TEN_W'(MAX_BURST)) ? r_tenure : r_tenure + 1'b1;
  assign w_others     = io_bus.req & ~r_grant;
  assign w_preempt    = (r_state == ST_GRANT) && (w_tenure_inc == TEN_W'(MAX_BURST)) && (|w_others);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_tenure <= '0;
    end else if (r_state == ST_GRANT) begin
      r_tenure <= w_tenure_inc;
    end else begin
      r_tenure <= '0;
    end
  end
`else
  assign w_preempt = 1'b0;
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_idx   <= w_idx_nxt;
      r_grant <= w_grant_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_idx_nxt   = r_idx;
    w_grant_nxt = r_grant;
    w_busy_nxt  = r_busy;
    case (r_state)
      ST_IDLE, ST_TURN: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_idx_nxt   = w_winner;
          w_grant_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
        end
      end
      ST_GRANT: begin
        // grant_idx is left alone so the read mux select stays put while idle.
        if (w_release || w_preempt) begin
          w_state_nxt = ST_TURN;
          w_ptr_nxt   = w_ptr_after;
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign io_bus.grant     = r_grant;
  assign io_bus.grant_idx = r_idx;
  assign io_bus.bus_busy  = r_busy;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and random bench for bus_arbiter (8- and 5-requester instances).
module tb_bus_arbiter;

  localparam int MB = 16;

  typedef struct {
    string       tag;
    bit          wide;
    logic [11:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_arbiter_if #(.NUM_REQ(8), .IDX_W(3)) bus8 ();
  bus_arbiter_if #(.NUM_REQ(5), .IDX_W(3)) bus5 ();

  bus_arbiter #(.NUM_REQ(8), .IDX_W(3)) u_dut8 (.i_clock(clk), .i_reset(rst), .io_bus(bus8));
  bus_arbiter #(.NUM_REQ(5), .IDX_W(3)) u_dut5 (.i_clock(clk), .i_reset(rst), .io_bus(bus5));

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  int   m_state, m_ptr, m_idx, m_ten;
  bit   m_busy;

  task automatic push(input string tag, input bit wide, input logic [7:0] g,
                      input logic [2:0] idx, input logic busy);
    exp_t e;
    e.tag  = tag;
    e.wide = wide;
    e.val  = {g, idx, busy};
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [11:0] obs;
    while (sb.size() != 0) begin
      e   = sb.pop_front();
      obs = e.wide ? {bus8.grant, bus8.grant_idx, bus8.bus_busy}
                   : {3'b000, bus5.grant, bus5.grant_idx, bus5.bus_busy};
      checks++;
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s grant_idx_busy observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    bus8.req = '0;
    bus5.req = '0;
    push("reset8", 1'b1, 8'h00, 3'd0, 1'b0);
    push("reset5", 1'b0, 8'h00, 3'd0, 1'b0);
    step();
    rst = 1'b0;
  endtask

  task automatic model_reset();
    m_state = 0; m_ptr = 0; m_idx = 0; m_ten = 0; m_busy = 1'b0;
  endtask

  // Behavioural reference: linear scan from ptr, level-sensitive release.
  task automatic model_edge(input logic [7:0] r);
    bit found;
    bit pre;
    int win;
    int ten_n;
    found = 1'b0;
    pre   = 1'b0;
    win   = 0;
    if (m_state == 1) begin
      ten_n = (m_ten < MB) ? m_ten + 1 : m_ten;
`ifdef BUS_ARB_BURST_LIMIT_EN
      pre = (ten_n == MB) && ((r & ~(8'(1) << m_idx)) != 8'h00);
`endif
      if (!r[m_idx] || pre) begin
        m_busy  = 1'b0;
        m_ptr   = (m_idx + 1) % 8;
        m_state = 2;
      end
      m_ten = ten_n;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (!found && r[(m_ptr + k) % 8]) begin
          found = 1'b1;
          win   = (m_ptr + k) % 8;
        end
      end
      m_ten = 0;
      if (found) begin
        m_idx   = win;
        m_busy  = 1'b1;
        m_state = 1;
      end else begin
        m_busy  = 1'b0;
        m_state = 0;
      end
    end
  endtask

  initial begin
    logic [7:0] prev_g;
    int         o;

    do_reset();

    // single requester, then pointer advance
    bus8.req = 8'b0000_0100;
    push("single_grant", 1'b1, 8'h04, 3'd2, 1'b1); step();
    push("single_hold",  1'b1, 8'h04, 3'd2, 1'b1); step();
    bus8.req = 8'h00;
    push("single_turn",  1'b1, 8'h00, 3'd2, 1'b0); step();
    push("single_idle",  1'b1, 8'h00, 3'd2, 1'b0); step();
    bus8.req = 8'h09;
    push("ptr_after_2",  1'b1, 8'h08, 3'd3, 1'b1); step();
    bus8.req = 8'h01;
    push("release_3",    1'b1, 8'h00, 3'd3, 1'b0); step();
    push("wrap8_to_0",   1'b1, 8'h01, 3'd0, 1'b1); step();
    bus8.req = 8'h00;
    push("release_0",    1'b1, 8'h00, 3'd0, 1'b0); step();
    push("idle_0",       1'b1, 8'h00, 3'd0, 1'b0); step();

    // fairness: all requesting, each owner holds 3 cycles then re-requests
    do_reset();
    bus8.req = 8'hFF;
    for (int t = 0; t < 9; t++) begin
      o = t % 8;
      for (int c = 0; c < 3; c++) begin
        push("fair_grant", 1'b1, 8'(1) << o, 3'(o), 1'b1);
        step();
      end
      bus8.req = 8'hFF & ~(8'(1) << o);
      push("fair_turn", 1'b1, 8'h00, 3'(o), 1'b0);
      step();
      bus8.req = 8'hFF;
    end
    bus8.req = 8'h00;
    push("fair_idle", 1'b1, 8'h00, 3'd0, 1'b0); step();

    // modulo-5 wrap on the 5-requester instance
    bus5.req = 5'b10000;
    push("w5_grant4",   1'b0, 8'h10, 3'd4, 1'b1); step();
    bus5.req = 5'b10001;
    push("w5_hold4",    1'b0, 8'h10, 3'd4, 1'b1); step();
    bus5.req = 5'b00001;
    push("w5_turn4",    1'b0, 8'h00, 3'd4, 1'b0); step();
    bus5.req = 5'b10001;
    push("w5_next0",    1'b0, 8'h01, 3'd0, 1'b1); step();
    bus5.req = 5'b10000;
    push("w5_turn0",    1'b0, 8'h00, 3'd0, 1'b0); step();
    bus5.req = 5'b10001;
    push("w5_next4",    1'b0, 8'h10, 3'd4, 1'b1); step();
    bus5.req = 5'b00000;
    push("w5_turn4b",   1'b0, 8'h00, 3'd4, 1'b0); step();
    push("w5_idle",     1'b0, 8'h00, 3'd4, 1'b0); step();

    // random traffic against the reference model
    do_reset();
    model_reset();
    prev_g = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      bus8.req = bus8.req ^ (8'($urandom) & 8'($urandom));
      model_edge(bus8.req);
      push("rand_model", 1'b1, m_busy ? (8'(1) << m_idx) : 8'h00, 3'(m_idx), m_busy);
      step();
      checks++;
      assert ($countones(bus8.grant) <= 1) else begin
        failures++;
        $error("FAIL rand_onehot grant=%h popcount_required<=1", bus8.grant);
      end
      checks++;
      assert (bus8.grant === (bus8.bus_busy ? (8'(1) << bus8.grant_idx) : 8'h00)) else begin
        failures++;
        $error("FAIL rand_invariant grant=%h required=%h", bus8.grant,
               bus8.bus_busy ? (8'(1) << bus8.grant_idx) : 8'h00);
      end
      checks++;
      assert (!(bus8.grant != 8'h00 && prev_g != 8'h00 && bus8.grant != prev_g)) else begin
        failures++;
        $error("FAIL rand_turnaround grant=%h previous=%h required_gap=1", bus8.grant, prev_g);
      end
      prev_g = bus8.grant;
    end

    // asynchronous reset during tenure of owner 6
    do_reset();
    bus8.req = 8'h40;
    push("a_grant6", 1'b1, 8'h40, 3'd6, 1'b1); step();
    push("a_hold6",  1'b1, 8'h40, 3'd6, 1'b1); step();
    #3;
    rst = 1'b1;
    #1;
    push("async_clear", 1'b1, 8'h00, 3'd0, 1'b0); drain();
    @(posedge clk);
    #1;
    push("reset_hold",  1'b1, 8'h00, 3'd0, 1'b0); drain();
    bus8.req = 8'hC0;
    rst      = 1'b0;
    push("restart_6",   1'b1, 8'h40, 3'd6, 1'b1); step();

    // tenure behaviour with a competing requester
    do_reset();
    bus8.req = 8'h02;
    for (int k = 0; k < 16; k++) begin
      if (k == 5) bus8.req = 8'h0A;
      push("burst_hold1", 1'b1, 8'h02, 3'd1, 1'b1);
      step();
    end
`ifdef BUS_ARB_BURST_LIMIT_EN
    push("burst_preempt", 1'b1, 8'h00, 3'd1, 1'b0); step();
    push("burst_next3",   1'b1, 8'h08, 3'd3, 1'b1); step();
`else
    for (int k = 0; k < 4; k++) begin
      push("unbounded_hold1", 1'b1, 8'h02, 3'd1, 1'b1);
      step();
    end
    bus8.req = 8'h08;
    push("unbounded_rel1", 1'b1, 8'h00, 3'd1, 1'b0); step();
    push("unbounded_next3", 1'b1, 8'h08, 3'd3, 1'b1); step();
`endif

    // no competitor: owner keeps the bus past the limit
    do_reset();
    bus8.req = 8'h02;
    for (int k = 0; k < 20; k++) begin
      push("solo_hold1", 1'b1, 8'h02, 3'd1, 1'b1);
      step();
    end
    bus8.req = 8'h0A;
`ifdef BUS_ARB_BURST_LIMIT_EN
    push("solo_preempt", 1'b1, 8'h00, 3'd1, 1'b0); step();
    push("solo_next3",   1'b1, 8'h08, 3'd3, 1'b1); step();
`else
    push("solo_keep",    1'b1, 8'h02, 3'd1, 1'b1); step();
    push("solo_keep2",   1'b1, 8'h02, 3'd1, 1'b1); step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
